itype_encoder: RTL and testbench



---
 rtl/itype_pkg.sv | 71 +++++++
 rtl/itype_fifo.sv | 55 +++++
 rtl/itype_encoder.sv | 121 ++++++++++++
 tb/tb_itype_encoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/itype_pkg.sv
// Shared definitions for the RV32I I-type encoder: opcodes, funct3 values,
// the NOP word, the field struct and the legality rule.
package itype_pkg;

  // Major opcodes of the I-type instruction groups handled here
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // OP-IMM funct3 values
  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  // LOAD funct3 values
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // JALR funct3 value
  localparam logic [2:0] F3_JALR = 3'b000;

  // Upper immediate bits (funct7) allowed for the shift-immediate forms
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Packing order matches the instruction word from bit 31 down to bit 0
  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } itype_fields_t;

  // True when the fields describe a defined OP-IMM, LOAD or JALR encoding
  function automatic logic itype_is_legal(input itype_fields_t f);
    logic legal;
    legal = 1'b0;
    case (f.opcode)
      OPC_OP_IMM: begin
        case (f.funct3)
          F3_ADDI, F3_SLTI, F3_SLTIU, F3_XORI, F3_ORI, F3_ANDI: legal = 1'b1;
          F3_SLLI: legal = (f.imm[11:5] == F7_ZERO);
          F3_SRXI: legal = (f.imm[11:5] == F7_ZERO) || (f.imm[11:5] == F7_SRA);
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        case (f.funct3)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OPC_JALR: legal = (f.funct3 == F3_JALR);
      default:  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/itype_fifo.sv
// Show-ahead FIFO of DEPTH words. Pointers carry one extra wrap bit so that
// full and empty can be told apart without an occupancy counter.
module itype_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags, guarded push/pop and next pointer values
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  // Pointer registers; reset flushes every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/itype_encoder.sv
// RV32I I-type instruction encoder feeding the decoder through a small FIFO.
// Optional legality checking is enabled by defining ITYPE_ENC_CHECK_EN; when
// undefined every accepted request is queued and the illegal outputs read 0.
module itype_encoder
  import itype_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rs1,
  input  logic [11:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_count,
  output logic [7:0]       illegal_count
);

  itype_fields_t    fields;
  logic [31:0]      word;
  logic             accept;
  logic             push;
  logic             pop_fire;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      fifo_rdata;
  logic [CNT_W-1:0] issued_count_q, issued_count_d;

  // Pack the request fields and work out the handshakes on both sides
  always_comb begin
    fields.imm    = in_imm;
    fields.rs1    = in_rs1;
    fields.funct3 = in_funct3;
    fields.rd     = in_rd;
    fields.opcode = in_opcode;
    word          = fields;
    accept        = in_valid && !fifo_full;
    pop_fire      = out_ready && !fifo_empty;
  end

`ifdef ITYPE_ENC_CHECK_EN
  logic       legal;
  logic       illegal_q, illegal_d;
  logic [7:0] illegal_count_q, illegal_count_d;

  // Drop illegal requests and track them with a pulse and a saturating count
  always_comb begin
    legal           = itype_is_legal(fields);
    push            = accept && legal;
    illegal_d       = accept && !legal;
    illegal_count_d = illegal_count_q;
    if (illegal_d && (illegal_count_q != 8'hFF)) begin
      illegal_count_d = illegal_count_q + 8'd1;
    end
  end

  // Illegal pulse and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q       <= 1'b0;
      illegal_count_q <= '0;
    end else begin
      illegal_q       <= illegal_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign illegal       = illegal_q;
  assign illegal_count = illegal_count_q;
`else
  // Without checking every accepted request goes straight into the queue
  always_comb begin
    push = accept;
  end

  assign illegal       = 1'b0;
  assign illegal_count = '0;
`endif

  itype_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop_fire),
    .wdata (word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Count words taken by the consumer; wraps naturally
  always_comb begin
    issued_count_d = issued_count_q + CNT_W'(pop_fire);
  end

  // Issued counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_count_q <= '0;
    end else begin
      issued_count_q <= issued_count_d;
    end
  end

  assign in_ready     = !fifo_full;
  assign out_valid    = !fifo_empty;
  assign out_instr    = fifo_empty ? NOP_INSTR : fifo_rdata;
  assign issued_count = issued_count_q;

endmodule

// File: tb/tb_itype_encoder.sv
// Self-checking bench for itype_encoder: directed cases followed by random
// traffic, all compared against a queue-based reference model.
module tb_itype_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef ITYPE_ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [2:0]       in_funct3;
  logic [4:0]       in_rs1;
  logic [11:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             illegal;
  logic [CNT_W-1:0] issued_count;
  logic [7:0]       illegal_count;

  itype_encoder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_rd         (in_rd),
    .in_funct3     (in_funct3),
    .in_rs1        (in_rs1),
    .in_imm        (in_imm),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .illegal       (illegal),
    .issued_count  (issued_count),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  int          exp_issued;
  int          exp_illcnt;
  bit          exp_ill;

  function automatic bit ref_legal(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [11:0] imm);
    logic [6:0] hi;
    hi = imm[11:5];
    if (op == 7'h13) begin
      if (f3 == 3'd1) return hi == 7'h00;
      if (f3 == 3'd5) return (hi == 7'h00) || (hi == 7'h20);
      return 1'b1;
    end
    if (op == 7'h03) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (op == 7'h67) return f3 == 3'd0;
    return 1'b0;
  endfunction

  task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the current cycle
  task automatic checkOutput();
    checkv("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    checkv("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    checkv("out_instr", out_instr, (exp_q.size() > 0) ? exp_q[0] : 32'h0000_0013);
    checkv("illegal", 32'(illegal), 32'(exp_ill));
    checkv("issued_count", 32'(issued_count), 32'(exp_issued));
    checkv("illegal_count", 32'(illegal_count), 32'(exp_illcnt));
  endtask

  // One clock: check, predict from the current inputs, advance to the next negedge
  task automatic tick();
    bit          push;
    bit          pop;
    bit          leg;
    logic [31:0] w;
    checkOutput();
    w    = {in_imm, in_rs1, in_funct3, in_rd, in_opcode};
    push = in_valid && (exp_q.size() < DEPTH);
    pop  = out_ready && (exp_q.size() > 0);
    leg  = CHECK_EN ? ref_legal(in_opcode, in_funct3, in_imm) : 1'b1;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_issued = 0;
      exp_illcnt = 0;
      exp_ill    = 1'b0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        exp_issued = (exp_issued + 1) % (1 << CNT_W);
      end
      if (push && leg) exp_q.push_back(w);
      exp_ill = push && !leg;
      if (push && !leg && exp_illcnt < 255) exp_illcnt++;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit v, input logic [6:0] op, input logic [4:0] rd,
                               input logic [2:0] f3, input logic [4:0] rs1,
                               input logic [11:0] imm, input bit ordy);
    in_valid  = v;
    in_opcode = op;
    in_rd     = rd;
    in_funct3 = f3;
    in_rs1    = rs1;
    in_imm    = imm;
    out_ready = ordy;
    tick();
  endtask

  task automatic idle(input bit ordy);
    applyStimulus(1'b0, 7'h00, 5'd0, 3'd0, 5'd0, 12'h000, ordy);
  endtask

  initial begin
    logic [6:0]  op;
    logic [11:0] imm;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_rd     = '0;
    in_funct3 = '0;
    in_rs1    = '0;
    in_imm    = '0;
    out_ready = 1'b0;
    exp_issued = 0;
    exp_illcnt = 0;
    exp_ill    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkv("rst_out_valid", 32'(out_valid), 32'd0);
    checkv("rst_out_instr", out_instr, 32'h0000_0013);
    checkv("rst_in_ready", 32'(in_ready), 32'd1);
    checkv("rst_illegal", 32'(illegal), 32'd0);
    checkv("rst_issued", 32'(issued_count), 32'd0);
    checkv("rst_illcnt", 32'(illegal_count), 32'd0);

    // addi x1,x2,5 then pop
    applyStimulus(1'b1, 7'h13, 5'd1, 3'd0, 5'd2, 12'h005, 1'b0);
    in_valid = 1'b0;
    checkv("addi_valid", 32'(out_valid), 32'd1);
    checkv("addi_word", out_instr, 32'h0051_0093);
    idle(1'b1);

    // lw x5,-4(x3)
    applyStimulus(1'b1, 7'h03, 5'd5, 3'd2, 5'd3, 12'hFFC, 1'b0);
    in_valid = 1'b0;
    checkv("lw_word", out_instr, 32'hFFC1_A283);
    idle(1'b1);

    // srai x4,x4,3
    applyStimulus(1'b1, 7'h13, 5'd4, 3'd5, 5'd4, 12'h403, 1'b0);
    in_valid = 1'b0;
    checkv("srai_word", out_instr, 32'h4032_5213);
    idle(1'b1);

    // slli with funct7 set, jalr with funct3 001
    applyStimulus(1'b1, 7'h13, 5'd4, 3'd1, 5'd2, 12'h403, 1'b0);
    in_valid = 1'b0;
    checkv("slli_illegal", 32'(illegal), 32'(CHECK_EN));
    applyStimulus(1'b1, 7'h67, 5'd1, 3'd1, 5'd1, 12'h000, 1'b0);
    in_valid = 1'b0;
    checkv("jalr_illegal", 32'(illegal), 32'(CHECK_EN));
    idle(1'b0);
    if (CHECK_EN) begin
      checkv("bad_illcnt", 32'(illegal_count), 32'd2);
      checkv("bad_empty", out_instr, 32'h0000_0013);
    end else begin
      checkv("slli_word", out_instr, 32'h4031_1213);
      idle(1'b1);
      checkv("jalr_word", out_instr, 32'h0000_90E7);
      idle(1'b1);
    end
    idle(1'b1);

    // Fill with out_ready low, fifth request stalls until space opens
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 7'h13, 5'(i + 1), 3'd0, 5'd7, 12'(i * 3 + 1), 1'b0);
    end
    checkv("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 7'h03, 5'd9, 3'd2, 5'd8, 12'h010, 1'b0);
    applyStimulus(1'b1, 7'h03, 5'd9, 3'd2, 5'd8, 12'h010, 1'b1);
    checkv("pop_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 7'h03, 5'd9, 3'd2, 5'd8, 12'h010, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Streaming from a clean counter state
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 7'h13, 5'(i), 3'd7, 5'(31 - i), 12'(i * 17), 1'b1);
    end
    idle(1'b1);
    checkv("stream_issued", 32'(issued_count), 32'd10);
    checkv("stream_empty", 32'(out_valid), 32'd0);

    // Reset with words queued and a handshake during reset
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 7'h03, 5'(i), 3'd0, 5'd1, 12'(i), 1'b0);
    end
    rst = 1'b1;
    applyStimulus(1'b1, 7'h13, 5'd3, 3'd0, 5'd3, 12'h033, 1'b1);
    rst = 1'b0;
    in_valid = 1'b0;
    checkv("flush_valid", 32'(out_valid), 32'd0);
    checkv("flush_issued", 32'(issued_count), 32'd0);
    checkv("flush_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0: op = 7'h13;
        1: op = 7'h03;
        2: op = 7'h67;
        default: op = 7'($urandom);
      endcase
      imm = 12'($urandom);
      case ($urandom_range(0, 2))
        0: imm[11:5] = 7'h00;
        1: imm[11:5] = 7'h20;
        default: ;
      endcase
      applyStimulus(bit'($urandom_range(0, 2) != 0), op, 5'($urandom), 3'($urandom),
                    5'($urandom), imm, bit'($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) idle(1'b1);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
